// File: rtl/qenc_pkg.sv
// Shared types and constants for the quadrature pattern generator:
// FSM state encoding and the phase -> {A,B} Gray table.
package qenc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } qenc_state_e;

   localparam logic [1:0] QENC_PHASE_TABLE [0:3] = '{2'b00, 2'b10, 2'b11, 2'b01};

   function automatic logic [1:0] qenc_phase_ab(input logic [1:0] phase);
      return QENC_PHASE_TABLE[phase];
   endfunction

endpackage

// File: rtl/qenc_period_timer.sv
// Loadable down-counter producing a one-cycle tick every programmed number of
// enabled clocks; the load value is retained for automatic reload.
module qenc_period_timer #(
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    load_i,
   input  logic [PERIOD_WIDTH-1:0] load_val_i,
   input  logic                    en_i,
   output logic                    tick_o
);

   localparam logic [PERIOD_WIDTH-1:0] CNT_ONE  = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PERIOD_WIDTH-1:0] CNT_ZERO = {PERIOD_WIDTH{1'b0}};

   logic [PERIOD_WIDTH-1:0] period_r;
   logic [PERIOD_WIDTH-1:0] count_r;
   logic                    tick_s;

   assign tick_s = en_i && (count_r == CNT_ONE);
   assign tick_o = tick_s;

   // Period latch and down-counter; a tick reloads the counter for the next interval.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         period_r <= CNT_ZERO;
         count_r  <= CNT_ZERO;
      end else if (load_i) begin
         period_r <= load_val_i;
         count_r  <= load_val_i;
      end else if (tick_s) begin
         period_r <= period_r;
         count_r  <= period_r;
      end else if (en_i && (count_r != CNT_ZERO)) begin
         period_r <= period_r;
         count_r  <= count_r - CNT_ONE;
      end else begin
         period_r <= period_r;
         count_r  <= count_r;
      end
   end

endmodule

// File: rtl/qenc_pattern_gen.sv
// Quadrature A/B/Z pattern generator: accepts signed step commands and emits
// Gray-sequenced edges at a programmable interval with live position tracking.
module qenc_pattern_gen
   import qenc_pkg::*;
#(
   parameter int POS_WIDTH    = 32,
   parameter int PERIOD_WIDTH = 16,
   parameter int INDEX_PERIOD = 4000
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [POS_WIDTH-1:0]    cmd_steps_i,
   input  logic [PERIOD_WIDTH-1:0] period_i,
   input  logic                    index_en_i,
   input  logic                    abort_i,
   output logic                    a_o,
   output logic                    b_o,
   output logic                    z_o,
   output logic [POS_WIDTH-1:0]    pos_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    aborted_o
);

   localparam int IDX_W = (INDEX_PERIOD > 1) ? $clog2(INDEX_PERIOD) : 1;
   localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(INDEX_PERIOD - 1);
   localparam logic [IDX_W-1:0]        IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]        IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [POS_WIDTH:0]      MAG_ZERO  = {(POS_WIDTH+1){1'b0}};
   localparam logic [POS_WIDTH:0]      MAG_ONE   = {{POS_WIDTH{1'b0}}, 1'b1};
   localparam logic [POS_WIDTH-1:0]    POS_ZERO  = {POS_WIDTH{1'b0}};
   localparam logic [POS_WIDTH-1:0]    POS_ONE   = {{(POS_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PERIOD_WIDTH-1:0] PER_ZERO  = {PERIOD_WIDTH{1'b0}};
   localparam logic [PERIOD_WIDTH-1:0] PER_ONE   = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

   qenc_state_e             state_r;
   qenc_state_e             state_nx_s;
   logic                    accept_s;
   logic                    step_s;
   logic                    abort_fin_s;
   logic                    enter_fin_s;
   logic                    tick_s;

   logic [POS_WIDTH:0]      ext_s;
   logic [POS_WIDTH:0]      mag_s;
   logic [PERIOD_WIDTH-1:0] period_eff_s;
   logic [1:0]              phase_nx_s;
   logic [POS_WIDTH-1:0]    pos_nx_s;
   logic [IDX_W-1:0]        idx_nx_s;

   logic [POS_WIDTH:0]      rem_r;
   logic                    dir_r;
   logic [1:0]              phase_r;
   logic [POS_WIDTH-1:0]    pos_r;
   logic [IDX_W-1:0]        idx_r;
   logic                    a_r;
   logic                    b_r;
   logic                    z_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    aborted_r;
   logic                    ready_r;

   // One extra magnitude bit keeps the most-negative step count representable.
   assign ext_s        = {cmd_steps_i[POS_WIDTH-1], cmd_steps_i};
   assign mag_s        = cmd_steps_i[POS_WIDTH-1] ? (~ext_s + MAG_ONE) : ext_s;
   assign period_eff_s = (period_i == PER_ZERO) ? PER_ONE : period_i;

   qenc_period_timer #(
      .PERIOD_WIDTH (PERIOD_WIDTH)
   ) u_timer (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .load_i     (accept_s),
      .load_val_i (period_eff_s),
      .en_i       (state_r == ST_RUN),
      .tick_o     (tick_s)
   );

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state and per-cycle strobes; abort takes priority over a same-cycle edge.
   always_comb begin
      state_nx_s  = state_r;
      accept_s    = 1'b0;
      step_s      = 1'b0;
      abort_fin_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               accept_s = 1'b1;
               if (mag_s == MAG_ZERO) begin
                  state_nx_s = ST_FINISH;
               end else begin
                  state_nx_s = ST_RUN;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort_i) begin
               abort_fin_s = 1'b1;
               state_nx_s  = ST_FINISH;
            end else if (tick_s) begin
               step_s = 1'b1;
               if (rem_r == MAG_ONE) begin
                  state_nx_s = ST_FINISH;
               end else begin
                  state_nx_s = ST_RUN;
               end
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_FINISH: state_nx_s = ST_IDLE;
         default:   state_nx_s = ST_IDLE;
      endcase
   end

   assign enter_fin_s = (state_nx_s == ST_FINISH) && (state_r != ST_FINISH);

   // Next phase, position and index value for a pending edge in the latched direction.
   always_comb begin
      phase_nx_s = phase_r;
      pos_nx_s   = pos_r;
      idx_nx_s   = idx_r;
      if (dir_r) begin
         phase_nx_s = phase_r - 2'd1;
         pos_nx_s   = pos_r - POS_ONE;
         if (idx_r == IDX_ZERO) begin
            idx_nx_s = IDX_LAST;
         end else begin
            idx_nx_s = idx_r - IDX_ONE;
         end
      end else begin
         phase_nx_s = phase_r + 2'd1;
         pos_nx_s   = pos_r + POS_ONE;
         if (idx_r == IDX_LAST) begin
            idx_nx_s = IDX_ZERO;
         end else begin
            idx_nx_s = idx_r + IDX_ONE;
         end
      end
   end

   // Command latch: remaining edge count and direction.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         rem_r <= MAG_ZERO;
         dir_r <= 1'b0;
      end else if (accept_s) begin
         rem_r <= mag_s;
         dir_r <= cmd_steps_i[POS_WIDTH-1];
      end else if (step_s) begin
         rem_r <= rem_r - MAG_ONE;
         dir_r <= dir_r;
      end else begin
         rem_r <= rem_r;
         dir_r <= dir_r;
      end
   end

   // Edge-driven phase, position, index and A/B/Z output registers.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         phase_r <= 2'd0;
         pos_r   <= POS_ZERO;
         idx_r   <= IDX_ZERO;
         a_r     <= 1'b0;
         b_r     <= 1'b0;
         z_r     <= 1'b0;
      end else if (step_s) begin
         phase_r    <= phase_nx_s;
         pos_r      <= pos_nx_s;
         idx_r      <= idx_nx_s;
         {a_r, b_r} <= qenc_phase_ab(phase_nx_s);
         z_r        <= index_en_i && (idx_nx_s == IDX_ZERO);
      end else if (state_r == ST_FINISH) begin
         z_r <= 1'b0;
      end else begin
         z_r <= z_r;
      end
   end

   // Status outputs; done/aborted pulse on the cycle FINISH is occupied.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         aborted_r <= 1'b0;
         ready_r   <= 1'b1;
      end else begin
         busy_r    <= (state_nx_s != ST_IDLE);
         done_r    <= enter_fin_s;
         aborted_r <= abort_fin_s;
         ready_r   <= (state_nx_s == ST_IDLE);
      end
   end

   assign cmd_ready_o = ready_r;
   assign a_o         = a_r;
   assign b_o         = b_r;
   assign z_o         = z_r;
   assign pos_o       = pos_r;
   assign busy_o      = busy_r;
   assign done_o      = done_r;
   assign aborted_o   = aborted_r;

endmodule

// File: tb/tb_qenc_pattern_gen.sv
// Directed bench for qenc_pattern_gen with an 8-bit position and an index
// period of 8, so wrap and Z behaviour are reachable in few cycles.
module tb_qenc_pattern_gen;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_steps;
   logic [15:0] period;
   logic        index_en;
   logic        abort;
   logic        a, b, z;
   logic [7:0]  pos;
   logic        busy, done, aborted;

   int          n_cmp = 0;
   int          n_bad = 0;

   int          edge_k [$];
   logic [1:0]  edge_ab [$];
   logic        edge_z [$];
   int          done_k;
   int          done_cnt;
   logic        done_abort;
   int          bad_gray;

   qenc_pattern_gen #(
      .POS_WIDTH    (8),
      .PERIOD_WIDTH (16),
      .INDEX_PERIOD (8)
   ) dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_steps_i (cmd_steps),
      .period_i    (period),
      .index_en_i  (index_en),
      .abort_i     (abort),
      .a_o         (a),
      .b_o         (b),
      .z_o         (z),
      .pos_o       (pos),
      .busy_o      (busy),
      .done_o      (done),
      .aborted_o   (aborted)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Issue one command and record every A/B change, relative to the accept edge (k=0).
   task automatic run_cmd(input logic [7:0] steps, input logic [15:0] per,
                          input int abort_at, input int budget);
      logic [1:0] prev;
      logic [1:0] cur;
      edge_k.delete();
      edge_ab.delete();
      edge_z.delete();
      done_k     = -1;
      done_cnt   = 0;
      done_abort = 1'b0;
      bad_gray   = 0;
      @(negedge clk);
      check_eq("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
      prev      = {a, b};
      cmd_valid = 1'b1;
      cmd_steps = steps;
      period    = per;
      for (int k = 0; k <= budget; k++) begin
         if (k > 0) begin
            abort = (k == abort_at);
            @(posedge clk);
            #1;
         end else begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
         end
         cur = {a, b};
         if (cur != prev) begin
            edge_k.push_back(k);
            edge_ab.push_back(cur);
            edge_z.push_back(z);
            if ((cur ^ prev) == 2'b11) bad_gray++;
            prev = cur;
         end
         if (done) begin
            done_cnt++;
            if (done_k < 0) begin
               done_k     = k;
               done_abort = aborted;
            end
         end
         if (done_k >= 0 && k > done_k + 2) break;
      end
      abort = 1'b0;
   endtask

   logic [1:0] fwd_tab [0:3];
   logic [1:0] rev_seq [0:4];
   logic [31:0] zmask;
   int          late_done;

   initial begin
      fwd_tab = '{2'b10, 2'b11, 2'b01, 2'b00};
      rev_seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_steps = 8'd0;
      period    = 16'd0;
      index_en  = 1'b0;
      abort     = 1'b0;

      // Reset state
      do_reset();
      @(negedge clk);
      check_eq("rst_ab",    {30'd0, a, b}, 32'd0);
      check_eq("rst_z",     {31'd0, z}, 32'd0);
      check_eq("rst_pos",   {24'd0, pos}, 32'd0);
      check_eq("rst_busy",  {31'd0, busy}, 32'd0);
      check_eq("rst_done",  {30'd0, done, aborted}, 32'd0);
      check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);

      // Forward 8 edges at period 25
      run_cmd(8'd8, 16'd25, 0, 300);
      check_eq("t1_edges", edge_k.size(), 32'd8);
      for (int i = 0; i < edge_k.size() && i < 8; i++) begin
         check_eq($sformatf("t1_k%0d", i), edge_k[i], 25 * (i + 1));
         check_eq($sformatf("t1_ab%0d", i), {30'd0, edge_ab[i]}, {30'd0, fwd_tab[i % 4]});
      end
      check_eq("t1_pos",     {24'd0, pos}, 32'd8);
      check_eq("t1_done_k",  done_k, 32'd200);
      check_eq("t1_done_n",  done_cnt, 32'd1);
      check_eq("t1_aborted", {31'd0, done_abort}, 32'd0);
      check_eq("t1_busy",    {31'd0, busy}, 32'd0);

      // Reverse 5 edges at period 3
      run_cmd(8'hFB, 16'd3, 0, 60);
      check_eq("t2_edges", edge_k.size(), 32'd5);
      for (int i = 0; i < edge_k.size() && i < 5; i++) begin
         check_eq($sformatf("t2_k%0d", i), edge_k[i], 3 * (i + 1));
         check_eq($sformatf("t2_ab%0d", i), {30'd0, edge_ab[i]}, {30'd0, rev_seq[i]});
      end
      check_eq("t2_pos",    {24'd0, pos}, 32'd3);
      check_eq("t2_gray",   bad_gray, 32'd0);
      check_eq("t2_done_k", done_k, 32'd15);

      // Index pulses every 8 edges from a fresh reset
      do_reset();
      index_en = 1'b1;
      run_cmd(8'd20, 16'd1, 0, 40);
      zmask = 32'd0;
      for (int i = 0; i < edge_z.size() && i < 32; i++) zmask[i] = edge_z[i];
      check_eq("t3_edges",  edge_k.size(), 32'd20);
      check_eq("t3_zmask",  zmask, 32'h0000_8080);
      check_eq("t3_pos",    {24'd0, pos}, 32'd20);
      check_eq("t3_done_k", done_k, 32'd20);
      check_eq("t3_z_end",  {31'd0, z}, 32'd0);
      index_en = 1'b0;

      // Abort after three edges
      run_cmd(8'd100, 16'd10, 35, 100);
      check_eq("t4_edges",   edge_k.size(), 32'd3);
      check_eq("t4_pos",     {24'd0, pos}, 32'd23);
      check_eq("t4_done_k",  done_k, 32'd35);
      check_eq("t4_done_n",  done_cnt, 32'd1);
      check_eq("t4_aborted", {31'd0, done_abort}, 32'd1);

      // Zero steps, then period 0 treated as 1
      run_cmd(8'd0, 16'd7, 0, 20);
      check_eq("t5_zero_edges",  edge_k.size(), 32'd0);
      check_eq("t5_zero_done_k", done_k, 32'd0);
      check_eq("t5_zero_pos",    {24'd0, pos}, 32'd23);
      run_cmd(8'd2, 16'd0, 0, 20);
      check_eq("t5_p0_edges", edge_k.size(), 32'd2);
      if (edge_k.size() == 2) begin
         check_eq("t5_p0_k0", edge_k[0], 32'd1);
         check_eq("t5_p0_k1", edge_k[1], 32'd2);
      end
      check_eq("t5_p0_pos", {24'd0, pos}, 32'd25);

      // Position wrap 127 -> -128
      run_cmd(8'd102, 16'd1, 0, 200);
      check_eq("t6_pos127", {24'd0, pos}, 32'h7F);
      run_cmd(8'd1, 16'd1, 0, 20);
      check_eq("t6_wrap", {24'd0, pos}, 32'h80);

      // Reset mid-run discards the command without done
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_steps = 8'd10;
      period    = 16'd5;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (12) @(negedge clk);
      check_eq("t6_busy_pre", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check_eq("t6_rst_ab",   {30'd0, a, b}, 32'd0);
      check_eq("t6_rst_pos",  {24'd0, pos}, 32'd0);
      check_eq("t6_rst_stat", {28'd0, z, busy, done, aborted}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      late_done = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done) late_done++;
      end
      check_eq("t6_no_done",   late_done, 32'd0);
      check_eq("t6_ready",     {31'd0, cmd_ready}, 32'd1);
      check_eq("t6_pos_still", {24'd0, pos}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
